// File: rtl/fft_sram_master.sv
// fft_sram_master: SRAM initiator that buffers one FFT frame.
// Samples arrive on a valid/ready stream and are written to SRAM in natural
// order. They are then read back and presented on a valid/ready output
// stream through a 2-entry skid FIFO.
// Optional build macro FFT_SRAM_BITREV_EN: when defined, drain addresses are
// bit-reversed (decimation-in-time order); otherwise they are natural order.
module fft_sram_master #(
  parameter int unsigned       LOG2_N    = 3,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam int unsigned      N        = 2 ** LOG2_N;
  localparam int unsigned      CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  ocnt;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;
  logic              inflight;

  logic              wr_hs;
  logic              pop;
  logic              issue;
  logic [1:0]        credit;
  logic [LOG2_N-1:0] rd_idx;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;

  // Drain index: bit-reversed or natural read order of the frame.
  always_comb begin
    rd_idx = '0;
`ifdef FFT_SRAM_BITREV_EN
    for (int unsigned i = 0; i < LOG2_N; i++) begin
      rd_idx[i] = rcnt[LOG2_N-1-i];
    end
`else
    rd_idx = rcnt[LOG2_N-1:0];
`endif
  end

  // Next-state, handshakes and SRAM strobes.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    out_valid    = (fifo_cnt != 2'd0);
    out_data     = fifo_mem[rd_ptr];
    pop          = 1'b0;
    wr_hs        = 1'b0;
    issue        = 1'b0;
    credit       = fifo_cnt + {1'b0, inflight};
    rd_off       = ADDR_W'(rd_idx);
    wr_off       = ADDR_W'(wcnt[LOG2_N-1:0]);
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;

    pop = out_valid && out_ready;

    unique case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        wr_hs    = in_valid;
        if (wr_hs && (wcnt == LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // A read may be issued when the slot it will land in is guaranteed
        // free, counting a pop happening in this same cycle; this keeps the
        // stream at one sample per cycle without overrunning the FIFO.
        issue = (rcnt != FULL_CNT) && ((credit < 2'd2) || pop);
        if (pop && (ocnt == LAST)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase

    // Strobes are suppressed during reset so SRAM is never disturbed by it.
    read_enable  = issue && !rst;
    write_enable = wr_hs && !rst;
    if (read_enable) begin
      address = BASE_ADDR + rd_off;
    end else if (write_enable) begin
      address    = BASE_ADDR + wr_off;
      write_data = in_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write, read-issue and output counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      rcnt <= '0;
      ocnt <= '0;
    end else begin
      if (state == IDLE)  wcnt <= '0;
      else if (wr_hs)     wcnt <= wcnt + CNT_W'(1);
      if (state == FILL) begin
        rcnt <= '0;
        ocnt <= '0;
      end else begin
        if (issue) rcnt <= rcnt + CNT_W'(1);
        if (pop)   ocnt <= ocnt + CNT_W'(1);
      end
    end
  end

  // Read return capture and 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= read_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sram_master.sv
// Testbench for fft_sram_master with a behavioural SRAM and a scoreboard.
`timescale 1ns/1ps
module tb_fft_sram_master;

  localparam int unsigned LOG2_N = 3;
  localparam int unsigned N      = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0010;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic        in_ready, out_valid, busy, done, read_enable, write_enable;
  logic [15:0] in_data, out_data, address, write_data, read_data;

  fft_sram_master #(
    .LOG2_N   (LOG2_N),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, junk when not reading.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (write_enable) mem[address[7:0]] <= write_data;
    read_data <= read_enable ? mem[address[7:0]] : 16'hDEAD;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [15:0] exp_w_addr_q[$];
  logic [15:0] exp_w_data_q[$];
  logic [15:0] exp_r_addr_q[$];
  logic [15:0] exp_out_q[$];
  int          pop_cyc_q[$];
  int          cyc = 0;
  int          reads_out = 0;
  int          pops = 0;
  bit          done_due = 0;
  bit          sb_on = 0;

  // Monitor: sample away from the active edge and compare against queues.
  always @(negedge clk) begin
    cyc++;
    if (sb_on) begin
      check("done_timing", done, done_due);
      done_due = 0;
      if (out_valid && out_ready) begin
        check("out_expected", exp_out_q.size() != 0, 1);
        if (exp_out_q.size() != 0) begin
          check("out_data", out_data, exp_out_q.pop_front());
          if (exp_out_q.size() == 0) done_due = 1;
        end
        pops++;
        pop_cyc_q.push_back(cyc);
      end
      if (read_enable) begin
        reads_out++;
        check("rd_expected", exp_r_addr_q.size() != 0, 1);
        if (exp_r_addr_q.size() != 0) check("rd_addr", address, exp_r_addr_q.pop_front());
        check("outstanding_le2", (reads_out - pops) <= 2, 1);
      end
      if (write_enable) begin
        check("wr_expected", exp_w_addr_q.size() != 0, 1);
        if (exp_w_addr_q.size() != 0) begin
          check("wr_addr", address, exp_w_addr_q.pop_front());
          check("wr_data", write_data, exp_w_data_q.pop_front());
        end
      end
      check("re_we_exclusive", read_enable & write_enable, 0);
      if (!read_enable && !write_enable) check("addr_idle_zero", address, 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rev(input int i);
    int r;
`ifdef FFT_SRAM_BITREV_EN
    r = {29'd0, i[0], i[1], i[2]};
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},   in_ready, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_out_data"},   out_data, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_re"},         read_enable, 0);
    check({tag, "_we"},         write_enable, 0);
    check({tag, "_address"},    address, 0);
    check({tag, "_write_data"}, write_data, 0);
  endtask

  task automatic clear_sb;
    exp_w_addr_q.delete();
    exp_w_data_q.delete();
    exp_r_addr_q.delete();
    exp_out_q.delete();
    pop_cyc_q.delete();
    reads_out = 0;
    pops      = 0;
    done_due  = 0;
  endtask

  // One frame: fill (optionally gapped), drain (optionally stalled or reset).
  task automatic run_frame(input logic [15:0] dbase, input bit gaps, input bit bp,
                           input int rst_after);
    logic [15:0] d [N];
    int hs, g, j;
    bit saw_done;
    clear_sb();
    for (int i = 0; i < N; i++) begin
      d[i] = dbase + 16'(i);
      exp_w_addr_q.push_back(BASE + 16'(i));
      exp_w_data_q.push_back(d[i]);
    end
    for (int i = 0; i < N; i++) begin
      j = rev(i);
      exp_r_addr_q.push_back(BASE + 16'(j));
      exp_out_q.push_back(d[j]);
    end
    out_ready = !bp;
    start = 1; tick; start = 0;
    hs = 0; g = 0;
    while (hs < N && g < 100) begin
      in_valid = gaps ? (g % 2 == 0) : 1'b1;
      in_data  = d[hs];
      @(negedge clk);
      check("in_ready_fill", in_ready, 1);
      if (in_valid && in_ready) hs++;
      tick;
      g++;
    end
    in_valid = 0;
    in_data  = 16'h0;
    check("fill_handshakes", hs, N);
    @(negedge clk);
    check("in_ready_after_fill", in_ready, 0);
    check("busy_drain", busy, 1);
    #1;
    check("writes_all_done", exp_w_addr_q.size(), 0);

    if (bp) begin
      g = 0;
      while (!out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("bp_first_valid", out_valid, 1);
      for (int k = 0; k < 4; k++) @(negedge clk);
      #1;
      check("bp_stall_no_read", read_enable, 0);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_outstanding", reads_out - pops, 2);
      tick;
      out_ready = 1;
    end

    if (rst_after > 0) begin
      g = 0;
      while (pops < rst_after && g < 60) begin
        tick;
        g++;
      end
      check("pops_before_rst", pops, rst_after);
      sb_on = 0;
      rst = 1;
      out_ready = 0;
      @(negedge clk);
      check("rst_cycle_we", write_enable, 0);
      check("rst_cycle_re", read_enable, 0);
      tick;
      rst = 0;
      out_ready = 1;
      @(negedge clk);
      check_idle("mid_drain_rst");
      @(negedge clk);
      check("inflight_discarded", out_valid, 0);
      clear_sb();
      sb_on = 1;
      tick;
      return;
    end

    saw_done = 0;
    g = 0;
    while (!saw_done && g < 60) begin
      @(negedge clk);
      saw_done = done;
      g++;
    end
    check("done_seen", saw_done, 1);
    #1;
    check("reads_left", exp_r_addr_q.size(), 0);
    check("outputs_left", exp_out_q.size(), 0);
    if (!bp && pop_cyc_q.size() == N)
      check("stream_span", pop_cyc_q[N-1] - pop_cyc_q[0], N - 1);
    @(negedge clk);
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_done", done, 0);
    tick;
  endtask

  typedef struct {
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic        exp_in_ready;
    logic        exp_busy;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  initial begin
    vec_t vecs [14];
    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b0, 1'(i % 2), 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0,  16'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0,  16'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b1, 1'b1, 16'h10, 16'h0055};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0066, 1'b1, 1'b1, 1'b1, 16'h11, 16'h0066};

    rst = 1; start = 0; in_valid = 0; in_data = 0; out_ready = 0;
    tick; tick;
    rst = 0;
    sb_on = 1;

    for (int i = 0; i < 14; i++) begin
      start     = vecs[i].start;
      in_valid  = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      in_data   = vecs[i].in_data;
      if (vecs[i].exp_we) begin
        exp_w_addr_q.push_back(vecs[i].exp_addr);
        exp_w_data_q.push_back(vecs[i].exp_wdata);
      end
      @(negedge clk);
      check("vec_in_ready",   in_ready, vecs[i].exp_in_ready);
      check("vec_busy",       busy, vecs[i].exp_busy);
      check("vec_we",         write_enable, vecs[i].exp_we);
      check("vec_address",    address, vecs[i].exp_addr);
      check("vec_write_data", write_data, vecs[i].exp_wdata);
      check("vec_re",         read_enable, 0);
      check("vec_out_valid",  out_valid, 0);
      check("vec_done",       done, 0);
      tick;
    end

    // Reset from FILL with a sample offered: no write, idle next cycle.
    sb_on = 0;
    rst = 1; start = 0; in_valid = 1; in_data = 16'h0077;
    @(negedge clk);
    check("fill_rst_we", write_enable, 0);
    tick;
    rst = 0; in_valid = 0;
    @(negedge clk);
    check_idle("fill_rst");
    clear_sb();
    sb_on = 1;
    tick;

    run_frame(16'h00A0, 1'b0, 1'b0, 0);
    run_frame(16'h00B0, 1'b0, 1'b1, 0);
    run_frame(16'h00C0, 1'b1, 1'b0, 0);
    run_frame(16'h00D0, 1'b0, 1'b0, 3);
    run_frame(16'h00E0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
